// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-bus decode, DMA read port and PPU register port of the
// $4014 sprite DMA sequencer, bundled as one interface.
// master = CPU bus / memory / PPU side, slave = oam_dma_ctrl.
// dma_done exists only when OAM_DMA_DONE_PULSE_EN is defined.
// dbg_state carries the controller FSM state for checkers and debug.
//
// Handshake: there is no valid/ready pair. A write is taken only in IDLE, on
// a clk edge where cpu_ce, dma_sel and cpu_we are all high. mem_data must be
// valid on the last of the RD_LAT cpu_ce cycles that mem_rd is held. Each
// ppu_cs_n high-to-low edge (ppu_we=1) carries exactly one OAM byte.
interface oam_dma_if;
  logic        dma_sel;
  logic        cpu_we;
  logic [7:0]  cpu_data;
  logic        cpu_halt;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        ppu_cs_n;
  logic [2:0]  ppu_reg_addr;
  logic        ppu_we;
  logic [7:0]  ppu_data;
  logic        dma_busy;
  logic [2:0]  dbg_state;
`ifdef OAM_DMA_DONE_PULSE_EN
  logic        dma_done;
`endif

  modport master (
    output dma_sel, cpu_we, cpu_data, mem_data,
    input  cpu_halt, mem_addr, mem_rd, ppu_cs_n, ppu_reg_addr, ppu_we,
           ppu_data, dma_busy, dbg_state
`ifdef OAM_DMA_DONE_PULSE_EN
    , input dma_done
`endif
  );

  modport slave (
    input  dma_sel, cpu_we, cpu_data, mem_data,
    output cpu_halt, mem_addr, mem_rd, ppu_cs_n, ppu_reg_addr, ppu_we,
           ppu_data, dma_busy, dbg_state
`ifdef OAM_DMA_DONE_PULSE_EN
    , output dma_done
`endif
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: $4014 sprite DMA sequencer.
// A CPU write of a page number halts the CPU, optionally burns one alignment
// cycle, then copies NUM_BYTES bytes from {page, idx} into OAM as a series
// of OAMDATA register writes. All state moves only on cpu_ce cycles.
// Optional macro OAM_DMA_DONE_PULSE_EN adds a one-clk dma_done pulse when
// a transfer completes normally.
module oam_dma_ctrl #(
  parameter int         NUM_BYTES   = 256,
  parameter int         RD_LAT      = 1,
  parameter logic [2:0] OAMDATA_REG = 3'd4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     cpu_ce,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DUMMY = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [7:0] LAST_LAT = 8'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic [7:0] page, page_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] lat_cnt, lat_nxt;
  logic [7:0] data_reg, data_nxt;
  logic       parity;
  logic       trigger;

  // The ce qualifier is applied at the register enable below.
  assign trigger       = bus.dma_sel & bus.cpu_we;
  assign bus.dbg_state = state;

  // Next-state/datapath selection plus Moore output decode of the state.
  always_comb begin
    state_nxt        = state;
    page_nxt         = page;
    idx_nxt          = idx;
    lat_nxt          = lat_cnt;
    data_nxt         = data_reg;
    bus.cpu_halt     = 1'b0;
    bus.dma_busy     = 1'b0;
    bus.mem_rd       = 1'b0;
    bus.mem_addr     = 16'h0000;
    bus.ppu_cs_n     = 1'b1;
    bus.ppu_reg_addr = 3'd0;
    bus.ppu_we       = 1'b0;
    bus.ppu_data     = 8'h00;
    unique case (state)
      S_IDLE: begin
        // A trigger outside IDLE never reaches this branch, so it is ignored.
        if (trigger) begin
          state_nxt = S_DUMMY;
          page_nxt  = bus.cpu_data;
          idx_nxt   = 8'h00;
        end
      end
      S_DUMMY: begin
        bus.cpu_halt = 1'b1;
        bus.dma_busy = 1'b1;
        // Odd parity means the first read would land on the wrong half of
        // the CPU cycle pair, so spend one more cycle to align.
        state_nxt    = parity ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        bus.cpu_halt = 1'b1;
        bus.dma_busy = 1'b1;
        state_nxt    = S_READ;
      end
      S_READ: begin
        bus.cpu_halt = 1'b1;
        bus.dma_busy = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {page, idx};
        if (lat_cnt == LAST_LAT) begin
          data_nxt  = bus.mem_data;
          lat_nxt   = 8'h00;
          state_nxt = S_WRITE;
        end else begin
          lat_nxt = lat_cnt + 8'd1;
        end
      end
      S_WRITE: begin
        bus.cpu_halt     = 1'b1;
        bus.dma_busy     = 1'b1;
        bus.ppu_cs_n     = 1'b0;
        bus.ppu_reg_addr = OAMDATA_REG;
        bus.ppu_we       = 1'b1;
        bus.ppu_data     = data_reg;
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = S_READ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; everything holds while cpu_ce is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      lat_cnt  <= 8'h00;
      data_reg <= 8'h00;
      parity   <= 1'b0;
    end else if (cpu_ce) begin
      state    <= state_nxt;
      page     <= page_nxt;
      idx      <= idx_nxt;
      lat_cnt  <= lat_nxt;
      data_reg <= data_nxt;
      parity   <= ~parity;
    end
  end

`ifdef OAM_DMA_DONE_PULSE_EN
  // One-clk completion pulse on the edge that leaves the final WRITE; it
  // clears on the next clk whatever cpu_ce does, and a reset abort skips it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dma_done <= 1'b0;
    end else begin
      bus.dma_done <= cpu_ce && (state == S_WRITE) && (idx == LAST_IDX);
    end
  end
`endif

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA sequencer for the $4014 (OAMDMA) port.
- On a CPU write of a page number it halts the CPU, then copies NUM_BYTES bytes from CPU address space {page, idx} into OAM.
- The copy is a series of OAMDATA ($2004) writes into the PPU register interface, using its active-low chip-select strobe.
- Sits between the CPU bus decoder, the CPU RDY line and the PPU register port.

Parameters:
- NUM_BYTES, 256: bytes transferred per DMA; index counter is 8 bits, transfer ends after index NUM_BYTES-1.
- RD_LAT, 1: CPU-bus read latency in ce cycles (>=1); READ state is held this many ce cycles.
- OAMDATA_REG, 3'd4: register select driven during writes.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- cpu_ce, input, 1: CPU cycle enable; all state, counters and parity advance only when high.
- dma_sel, input, 1: CPU bus decode of $4014.
- cpu_we, input, 1: CPU write strobe.
- cpu_data, input, 8: CPU write data (page number).
- cpu_halt, output, 1: to CPU RDY (1 = CPU stalled).
- mem_addr, output, 16: DMA read address.
- mem_rd, output, 1: DMA read strobe.
- mem_data, input, 8: DMA read data, valid at the last READ ce cycle.
- ppu_cs_n, output, 1: PPU register chip select, active low.
- ppu_reg_addr, output, 3: PPU register select.
- ppu_we, output, 1: PPU register write enable.
- ppu_data, output, 8: PPU register write data.
- dma_busy, output, 1: high from trigger until return to IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, page=0, idx=0, lat_cnt=0, parity=0, data_reg=0.
- Reset outputs: cpu_halt=0, mem_rd=0, mem_addr=0, ppu_cs_n=1, ppu_reg_addr=0, ppu_we=0, ppu_data=0, dma_busy=0.
- A reset mid-transfer abandons the transfer; no partial-state resume.
- parity toggles on every clk edge with cpu_ce=1, in all states.
- Outputs are Moore decodes of registered state: no combinational path from any input to any output.
- Trigger: dma_sel & cpu_we & cpu_ce in IDLE latches page=cpu_data, idx=0 and moves to DUMMY.
- A trigger while not IDLE is ignored: page unchanged, no restart.
- State advances below occur only on ce cycles.
- DUMMY: cpu_halt=1, 1 ce cycle. Exit: parity==1 -> ALIGN, else -> READ.
- ALIGN: cpu_halt=1, 1 ce cycle, -> READ.
- READ: mem_rd=1, mem_addr={page, idx}.
  - Held RD_LAT ce cycles (lat_cnt counts up from 0).
  - On the last cycle data_reg<=mem_data, lat_cnt<=0, -> WRITE.
- WRITE: ppu_cs_n=0, ppu_reg_addr=OAMDATA_REG, ppu_we=1, ppu_data=data_reg; 1 ce cycle.
  - idx==NUM_BYTES-1 -> IDLE.
  - Otherwise idx<=idx+1 -> READ.
- ppu_cs_n is high in every non-WRITE state, so each byte gives exactly one high-to-low edge to the register interface.
  - The edge may stretch over several clk cycles when cpu_ce is low; it is still one write per byte.
- cpu_halt=dma_busy=1 in DUMMY, ALIGN, READ and WRITE; both drop on the edge entering IDLE.
- Duration after trigger edge: 1 + parity_at_DUMMY_exit + NUM_BYTES*(RD_LAT+1) ce cycles.
  - Default values give 513 or 514.
- idx is 8 bits; no wrap beyond NUM_BYTES-1; mem_addr low byte never carries into page.
- cpu_ce low: all registers hold, outputs stable.

Optional Feature:
- Macro: OAM_DMA_DONE_PULSE_EN.
- Defined: adds output dma_done (1 bit, reset 0), registered, high for exactly one clk cycle on the edge that enters IDLE from WRITE.
  - Not asserted when a transfer is aborted by reset.
- Undefined: port absent, no extra logic.

Test Plan:
- Even-parity trigger, cpu_data=8'h02, memory[16'h0200+i]=i^8'hA5, cpu_ce=1 -> no ALIGN state.
  - Exactly 256 ppu_cs_n falling edges with ppu_reg_addr=4, ppu_we=1, byte i = i^8'hA5.
  - cpu_halt high 513 cycles.
- Odd-parity trigger, same data -> ALIGN inserted, cpu_halt high 514 cycles, identical byte stream.
- cpu_ce toggling 1-of-3 clocks during transfer -> same 256-byte sequence; ppu_cs_n low periods each span 3 clk cycles.
- Second $4014 write (cpu_data=8'h07) at byte 100 -> ignored; mem_addr stays 16'h02xx; transfer completes normally.
- reset asserted at byte 50 -> same-clock-edge-independent return to cpu_halt=0, ppu_cs_n=1; a new trigger restarts at idx=0.
- RD_LAT=2 build, page 8'h03 -> READ held 2 ce cycles per byte, 769/770-cycle halt; data sampled on the 2nd READ cycle.
  - With OAM_DMA_DONE_PULSE_EN defined, dma_done is a single-cycle pulse at the end.
